// File: rtl/host_cfg_responder_pkg.sv
// rtl/host_cfg_responder_pkg.sv - shared widths, defaults and FSM encoding for the host config responder
// Contents: bus widths, address/data types, default error read data,
// responder state encoding (visible to benches for probing) and a saturating increment.
package host_cfg_responder_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam data_t ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/host_cfg_responder_timeout_counter.sv
// rtl/host_cfg_responder_timeout_counter.sv - clear/enable counter with terminal-count flag
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to zero (wins over en_i)
//   en_i       : count up by one
//   tc_o       : count equals TERMINAL
module timeout_counter #(
  parameter int WIDTH    = 6,
  parameter int TERMINAL = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/host_cfg_responder.sv
// rtl/host_cfg_responder.sv - host write/read config responder forwarding to the register backend
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   write_en/rdy/addr/data         : host single-beat write
//   read_en/rdy/addr               : host read request
//   read_data_vld/rdy, read_data   : host read response
//   cfg_req/we/addr/wdata, cfg_gnt : backend request channel
//   cfg_rvld, cfg_rdata            : backend read return
//   err_cnt                        : saturating out-of-range + timeout count
module host_cfg_responder
  import host_cfg_responder_pkg::*;
#(
  parameter addr_t ADDR_LIMIT = 16'h0400,
  parameter int    TIMEOUT    = 64,
  parameter data_t ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_en,
  output logic        write_rdy,
  input  addr_t       write_addr,
  input  data_t       write_data,
  input  logic        read_en,
  output logic        read_rdy,
  input  addr_t       read_addr,
  input  logic        read_data_rdy,
  output logic        read_data_vld,
  output data_t       read_data,
  output logic        cfg_req,
  output logic        cfg_we,
  output addr_t       cfg_addr,
  output data_t       cfg_wdata,
  input  logic        cfg_gnt,
  input  logic        cfg_rvld,
  input  data_t       cfg_rdata,
  output logic [7:0]  err_cnt
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e     state_q, state_d;
  addr_t      addr_q, addr_d;
  data_t      wdata_q, wdata_d;
  data_t      rdata_q, rdata_d;
  logic [7:0] err_q, err_d;
  logic       tmo_clr, tmo_en, tmo_tc;

  timeout_counter #(
    .WIDTH    (CW),
    .TERMINAL (TIMEOUT - 1)
  ) u_tmo (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Write wins when both requests arrive together; the host holds read_en.
        if (write_en) begin
          if (write_addr < ADDR_LIMIT) begin
            addr_d  = write_addr;
            wdata_d = write_data;
            state_d = ST_WR_ISSUE;
          end else begin
            err_d = sat_inc8(err_q);
          end
        end else if (read_en) begin
          if (read_addr < ADDR_LIMIT) begin
            addr_d  = read_addr;
            state_d = ST_RD_ISSUE;
          end else begin
            rdata_d = ERR_DATA;
            err_d   = sat_inc8(err_q);
            state_d = ST_RESP;
          end
        end
      end
      ST_WR_ISSUE: begin
        if (cfg_gnt) state_d = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        if (cfg_gnt) begin
          tmo_clr = 1'b1;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // A response landing on the terminal cycle still counts as a good read.
        if (cfg_rvld) begin
          rdata_d = cfg_rdata;
          state_d = ST_RESP;
        end else if (tmo_tc) begin
          rdata_d = ERR_DATA;
          err_d   = sat_inc8(err_q);
          state_d = ST_RESP;
        end else begin
          tmo_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (read_data_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Ready is gated by reset so the host never sees it high during reset.
  assign write_rdy     = rst && (state_q == ST_IDLE);
  assign read_rdy      = rst && (state_q == ST_IDLE);
  assign read_data_vld = (state_q == ST_RESP);
  assign read_data     = rdata_q;
  assign cfg_req       = (state_q == ST_WR_ISSUE) || (state_q == ST_RD_ISSUE);
  assign cfg_we        = (state_q == ST_WR_ISSUE);
  assign cfg_addr      = addr_q;
  assign cfg_wdata     = wdata_q;
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_host_cfg_responder.sv
// tb/tb_host_cfg_responder.sv - directed self-checking bench for host_cfg_responder
module tb_host_cfg_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic        write_rdy;
  logic [15:0] write_addr;
  logic [31:0] write_data;
  logic        read_en;
  logic        read_rdy;
  logic [15:0] read_addr;
  logic        read_data_rdy;
  logic        read_data_vld;
  logic [31:0] read_data;
  logic        cfg_req;
  logic        cfg_we;
  logic [15:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_gnt;
  logic        cfg_rvld;
  logic [31:0] cfg_rdata;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  host_cfg_responder dut (
    .clk           (clk),
    .rst           (rst),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .read_en       (read_en),
    .read_rdy      (read_rdy),
    .read_addr     (read_addr),
    .read_data_rdy (read_data_rdy),
    .read_data_vld (read_data_vld),
    .read_data     (read_data),
    .cfg_req       (cfg_req),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_gnt       (cfg_gnt),
    .cfg_rvld      (cfg_rvld),
    .cfg_rdata     (cfg_rdata),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; write_en = 0; read_en = 0; read_data_rdy = 0;
    write_addr = '0; write_data = '0; read_addr = '0;
    cfg_gnt = 0; cfg_rvld = 0; cfg_rdata = '0;
    tick(); tick();
    checks++;
    if (write_rdy !== 1'b0 || read_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_rdy_low: wr=%b rd=%b expected 0 0", write_rdy, read_rdy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({write_rdy, read_rdy, cfg_req, cfg_we, read_data_vld} !== 5'b11000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 11000", {write_rdy, read_rdy, cfg_req, cfg_we, read_data_vld});
    end
    checks++;
    if (cfg_addr !== 16'h0 || cfg_wdata !== 32'h0 || read_data !== 32'h0 || err_cnt !== 8'h0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h err=%h expected zeros", cfg_addr, cfg_wdata, read_data, err_cnt);
    end
  endtask

  task automatic test_write();
    cfg_gnt = 1; write_en = 1; write_addr = 16'h0010; write_data = 32'h1234_5678;
    tick();
    write_en = 0;
    checks++;
    if ({cfg_req, cfg_we, write_rdy} !== 3'b110 || cfg_addr !== 16'h0010 || cfg_wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL write_issue: req/we/rdy=%b addr=%h data=%h expected 110 0010 12345678", {cfg_req, cfg_we, write_rdy}, cfg_addr, cfg_wdata);
    end
    tick();
    checks++;
    if (cfg_req !== 1'b0 || write_rdy !== 1'b1) begin
      errors++; $display("FAIL write_done: req=%b rdy=%b expected 0 1", cfg_req, write_rdy);
    end
  endtask

  task automatic test_read();
    cfg_gnt = 1; read_en = 1; read_addr = 16'h0010;
    tick();
    read_en = 0;
    checks++;
    if ({cfg_req, cfg_we, read_rdy} !== 3'b100 || cfg_addr !== 16'h0010) begin
      errors++; $display("FAIL read_issue: req/we/rdy=%b addr=%h expected 100 0010", {cfg_req, cfg_we, read_rdy}, cfg_addr);
    end
    tick();
    checks++;
    if (cfg_req !== 1'b0 || read_data_vld !== 1'b0) begin
      errors++; $display("FAIL read_wait: req=%b vld=%b expected 0 0", cfg_req, read_data_vld);
    end
    tick(); tick();
    cfg_rvld = 1; cfg_rdata = 32'hCAFE_0001;
    tick();
    cfg_rvld = 0; cfg_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (read_data_vld !== 1'b1 || read_data !== 32'hCAFE_0001 || read_rdy !== 1'b0) begin
        errors++; $display("FAIL read_hold[%0d]: vld=%b data=%h rdy=%b expected 1 cafe0001 0", i, read_data_vld, read_data, read_rdy);
      end
      tick();
    end
    read_data_rdy = 1;
    checks++;
    if (read_data_vld !== 1'b1 || read_data !== 32'hCAFE_0001) begin
      errors++; $display("FAIL read_last: vld=%b data=%h expected 1 cafe0001", read_data_vld, read_data);
    end
    tick();
    read_data_rdy = 0;
    checks++;
    if (read_data_vld !== 1'b0 || read_rdy !== 1'b1) begin
      errors++; $display("FAIL read_release: vld=%b rdy=%b expected 0 1", read_data_vld, read_rdy);
    end
  endtask

  task automatic test_priority();
    cfg_gnt = 1;
    write_en = 1; write_addr = 16'h0020; write_data = 32'hAAAA_5555;
    read_en = 1; read_addr = 16'h0030;
    tick();
    write_en = 0;
    checks++;
    if ({cfg_req, cfg_we} !== 2'b11 || cfg_addr !== 16'h0020 || cfg_wdata !== 32'hAAAA_5555) begin
      errors++; $display("FAIL prio_write_first: req/we=%b addr=%h data=%h expected 11 0020 aaaa5555", {cfg_req, cfg_we}, cfg_addr, cfg_wdata);
    end
    tick();
    checks++;
    if (read_rdy !== 1'b1 || cfg_req !== 1'b0) begin
      errors++; $display("FAIL prio_idle: rdy=%b req=%b expected 1 0", read_rdy, cfg_req);
    end
    tick();
    read_en = 0;
    checks++;
    if ({cfg_req, cfg_we} !== 2'b10 || cfg_addr !== 16'h0030) begin
      errors++; $display("FAIL prio_read_next: req/we=%b addr=%h expected 10 0030", {cfg_req, cfg_we}, cfg_addr);
    end
    tick();
    cfg_rvld = 1; cfg_rdata = 32'h0BAD_F00D;
    tick();
    cfg_rvld = 0;
    read_data_rdy = 1;
    checks++;
    if (read_data_vld !== 1'b1 || read_data !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL prio_read_data: vld=%b data=%h expected 1 0badf00d", read_data_vld, read_data);
    end
    tick();
    read_data_rdy = 0;
  endtask

  task automatic test_out_of_range();
    cfg_gnt = 0;
    write_en = 1; write_addr = 16'h0400; write_data = 32'h5555_0000;
    tick();
    write_en = 0;
    checks++;
    if (cfg_req !== 1'b0 || write_rdy !== 1'b1 || err_cnt !== 8'd1) begin
      errors++; $display("FAIL oor_write: req=%b rdy=%b err=%0d expected 0 1 1", cfg_req, write_rdy, err_cnt);
    end
    read_en = 1; read_addr = 16'h0500;
    tick();
    read_en = 0;
    checks++;
    if (cfg_req !== 1'b0 || read_data_vld !== 1'b1 || read_data !== 32'hDEAD_BEEF || err_cnt !== 8'd2) begin
      errors++; $display("FAIL oor_read: req=%b vld=%b data=%h err=%0d expected 0 1 deadbeef 2", cfg_req, read_data_vld, read_data, err_cnt);
    end
    read_data_rdy = 1;
    tick();
    read_data_rdy = 0;
    cfg_gnt = 1;
    write_en = 1; write_addr = 16'h03FF; write_data = 32'h0000_03FF;
    tick();
    write_en = 0;
    checks++;
    if (cfg_req !== 1'b1 || cfg_addr !== 16'h03FF || err_cnt !== 8'd2) begin
      errors++; $display("FAIL edge_write_03ff: req=%b addr=%h err=%0d expected 1 03ff 2", cfg_req, cfg_addr, err_cnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    cfg_gnt = 1; read_en = 1; read_addr = 16'h0040;
    tick();
    read_en = 0;
    tick();
    for (int i = 0; i < 63; i++) tick();
    checks++;
    if (read_data_vld !== 1'b0) begin
      errors++; $display("FAIL timeout_early: vld=%b after 63 wait cycles expected 0", read_data_vld);
    end
    tick();
    checks++;
    if (read_data_vld !== 1'b1 || read_data !== 32'hDEAD_BEEF || err_cnt !== 8'd3) begin
      errors++; $display("FAIL timeout_resp: vld=%b data=%h err=%0d expected 1 deadbeef 3", read_data_vld, read_data, err_cnt);
    end
    cfg_rvld = 1; cfg_rdata = 32'h7777_7777;
    tick();
    cfg_rvld = 0;
    checks++;
    if (read_data_vld !== 1'b1 || read_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL timeout_stray: vld=%b data=%h expected 1 deadbeef", read_data_vld, read_data);
    end
    read_data_rdy = 1;
    tick();
    read_data_rdy = 0;
    cfg_rvld = 1;
    tick();
    cfg_rvld = 0;
    checks++;
    if (read_rdy !== 1'b1 || read_data_vld !== 1'b0 || err_cnt !== 8'd3) begin
      errors++; $display("FAIL timeout_after: rdy=%b vld=%b err=%0d expected 1 0 3", read_rdy, read_data_vld, err_cnt);
    end
  endtask

  task automatic test_reset_midop();
    cfg_gnt = 1; read_en = 1; read_addr = 16'h0050;
    tick();
    read_en = 0;
    tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({write_rdy, read_rdy, cfg_req, cfg_we, read_data_vld} !== 5'b00000 ||
        cfg_addr !== 16'h0 || cfg_wdata !== 32'h0 || read_data !== 32'h0 || err_cnt !== 8'h0) begin
      errors++; $display("FAIL midop_reset: ctrl=%b addr=%h wdata=%h rdata=%h err=%0d expected all zero",
                         {write_rdy, read_rdy, cfg_req, cfg_we, read_data_vld}, cfg_addr, cfg_wdata, read_data, err_cnt);
    end
    tick();
    rst = 1'b1;
    tick();
    write_en = 1; write_addr = 16'h0060; write_data = 32'h1111_2222;
    tick();
    write_en = 0;
    checks++;
    if ({cfg_req, cfg_we} !== 2'b11 || cfg_addr !== 16'h0060 || cfg_wdata !== 32'h1111_2222) begin
      errors++; $display("FAIL midop_write: req/we=%b addr=%h data=%h expected 11 0060 11112222", {cfg_req, cfg_we}, cfg_addr, cfg_wdata);
    end
    tick();
    checks++;
    if (write_rdy !== 1'b1 || cfg_req !== 1'b0) begin
      errors++; $display("FAIL midop_write_done: rdy=%b req=%b expected 1 0", write_rdy, cfg_req);
    end
  endtask

  task automatic test_saturation();
    write_en = 1; write_addr = 16'hFFFF;
    for (int i = 0; i < 256; i++) tick();
    write_en = 0;
    checks++;
    if (err_cnt !== 8'hFF) begin
      errors++; $display("FAIL err_saturate: err=%h expected ff", err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_priority();
    test_out_of_range();
    test_timeout();
    test_reset_midop();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
